// File: rtl/cmd_exec_regbank.sv
// Packet command executor: decodes one RX payload per command, runs register/interrupt
// operations against the fabric and returns exactly one reply packet per accepted command.
module cmd_exec_regbank #(
  parameter int unsigned N_IN      = 16,
  parameter int unsigned N_OUT     = 32,
  parameter int unsigned N_INT     = 32,
  parameter int unsigned BUF_BYTES = 16,
  parameter logic [15:0] VERSION   = 16'hBACE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_packet_done,
  input  logic                     rx_packet_error,
  input  logic                     rx_buffer_valid,
  input  logic [7:0]               rx_payload_len,
  input  logic [8*BUF_BYTES-1:0]   rx_buf,
  input  logic                     tx_busy,
  output logic                     tx_packet_wr,
  output logic [7:0]               tx_payload_len,
  output logic [8*BUF_BYTES-1:0]   tx_buf,
  input  logic [32*N_IN-1:0]       in_regs,
  output logic [32*N_OUT-1:0]      out_regs,
  output logic [N_OUT-1:0]         out_strobes,
  input  logic [N_INT-1:0]         int_in,
  output logic                     int_pending,
  output logic                     cmd_busy
);

  localparam int unsigned BW     = 8 * BUF_BYTES;
  localparam int unsigned IW_IN  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned IW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_TX} state_t;

  state_t             state;
  logic [47:0]        rx_q;
  logic [7:0]         len_q;
  logic [31:0]        in_arr  [N_IN];
  logic [31:0]        out_arr [N_OUT];
  logic [N_INT-1:0]   int_enable;
  logic [N_INT-1:0]   int_status;
  logic [N_INT-1:0]   en_next;
  logic [N_INT-1:0]   clr_mask;
  logic [7:0]         opc;
  logic [7:0]         idx;
  logic [BW-1:0]      rep;
  logic [7:0]         rep_len;
  logic [7:0]         min_len;
  logic               known;
  logic               in_range;
  logic               ok;
  logic               exec;
  logic               do_wr;
  logic               do_en;
  logic               do_clr;
  logic               unused_ok;

  assign opc         = rx_q[7:0];
  assign idx         = rx_q[15:8];
  assign exec        = (state == EXEC);
  assign int_pending = |int_status;
  assign cmd_busy    = (state != IDLE);
  assign unused_ok   = ^{rx_buf, rx_q};

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) in_arr[i] = in_regs[32*i +: 32];
  end

  always_comb begin
    for (int unsigned i = 0; i < N_OUT; i++) out_regs[32*i +: 32] = out_arr[i];
  end

  // Decode the latched command; errors take priority: opcode, then length, then index.
  always_comb begin
    rep      = '0;
    rep_len  = 8'd0;
    ok       = 1'b0;
    min_len  = 8'd1;
    known    = 1'b1;
    in_range = 1'b1;
    case (opc)
      8'h01: min_len = 8'd1;
      8'h02: begin min_len = 8'd2; in_range = 32'(idx) < N_IN;  end
      8'h03: begin min_len = 8'd6; in_range = 32'(idx) < N_OUT; end
      8'h04: min_len = 8'd1;
      8'h05: min_len = 8'd5;
      default: known = 1'b0;
    endcase
    if (!known) begin
      rep[15:0] = 16'h0180;
      rep_len   = 8'd2;
    end else if (len_q < min_len) begin
      rep[15:0] = 16'h0380;
      rep_len   = 8'd2;
    end else if (!in_range) begin
      rep[15:0] = 16'h0280;
      rep_len   = 8'd2;
    end else begin
      ok = 1'b1;
      case (opc)
        8'h01: begin rep[23:0] = {VERSION[7:0], VERSION[15:8], 8'h81}; rep_len = 8'd3; end
        8'h02: begin rep[39:0] = {in_arr[IW_IN'(idx)], 8'h81};        rep_len = 8'd5; end
        8'h04: begin rep[39:0] = {32'(int_status), 8'h81};            rep_len = 8'd5; end
        default: begin rep[7:0] = 8'h81; rep_len = 8'd1; end
      endcase
    end
  end

  assign do_wr    = exec && ok && (opc == 8'h03);
  assign do_en    = exec && ok && (opc == 8'h05);
  assign do_clr   = exec && ok && (opc == 8'h04);
  assign en_next  = do_en ? rx_q[8 +: N_INT] : int_enable;
  assign clr_mask = do_clr ? int_status : '0;

  // Reported status bits clear, but a source still high this cycle re-sets its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rx_q           <= '0;
      len_q          <= 8'd0;
      tx_packet_wr   <= 1'b0;
      tx_payload_len <= 8'd0;
      tx_buf         <= '0;
      out_strobes    <= '0;
      int_enable     <= '0;
      int_status     <= '0;
      for (int unsigned i = 0; i < N_OUT; i++) out_arr[i] <= '0;
    end else begin
      out_strobes <= '0;
      int_enable  <= en_next;
      int_status  <= en_next & ((int_status & ~clr_mask) | int_in);
      case (state)
        IDLE: begin
          if (rx_packet_done && rx_buffer_valid && !rx_packet_error) begin
            rx_q  <= rx_buf[47:0];
            len_q <= rx_payload_len;
            state <= EXEC;
          end
        end
        EXEC: begin
          tx_buf         <= rep;
          tx_payload_len <= rep_len;
          if (do_wr) begin
            out_arr[IW_OUT'(idx)]     <= rx_q[47:16];
            out_strobes[IW_OUT'(idx)] <= 1'b1;
          end
          tx_packet_wr <= !tx_busy;
          state        <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_packet_wr) begin
            tx_packet_wr <= 1'b0;
            state        <= IDLE;
          end else if (!tx_busy) begin
            tx_packet_wr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_exec_regbank.sv
// Randomised scoreboard bench for cmd_exec_regbank against a command-level reference model.
module tb_cmd_exec_regbank;

  logic           clk = 1'b0;
  logic           rst;
  logic           rx_packet_done;
  logic           rx_packet_error;
  logic           rx_buffer_valid;
  logic [7:0]     rx_payload_len;
  logic [127:0]   rx_buf;
  logic           tx_busy;
  logic           tx_packet_wr;
  logic [7:0]     tx_payload_len;
  logic [127:0]   tx_buf;
  logic [511:0]   in_regs;
  logic [1023:0]  out_regs;
  logic [31:0]    out_strobes;
  logic [31:0]    int_in;
  logic           int_pending;
  logic           cmd_busy;

  always #5 clk = ~clk;

  cmd_exec_regbank #(
    .N_IN(16), .N_OUT(32), .N_INT(32), .BUF_BYTES(16), .VERSION(16'hBACE)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_packet_done(rx_packet_done), .rx_packet_error(rx_packet_error),
    .rx_buffer_valid(rx_buffer_valid), .rx_payload_len(rx_payload_len), .rx_buf(rx_buf),
    .tx_busy(tx_busy), .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len),
    .tx_buf(tx_buf), .in_regs(in_regs), .out_regs(out_regs), .out_strobes(out_strobes),
    .int_in(int_in), .int_pending(int_pending), .cmd_busy(cmd_busy)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [135:0]  rep_q[$];
  logic [31:0]   strobe_q[$];
  logic [31:0]   m_out[32];
  logic [31:0]   m_en;
  logic [31:0]   m_stat;
  logic [31:0]   m_hold;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (out_regs[32*i +: 32] !== m_out[i]) begin
        bad = 1'b1;
        $display("FAIL out_regs[%0d]: got %h expected %h", i, out_regs[32*i +: 32], m_out[i]);
      end
    end
    n_checks++;
    if (bad) n_fail++;
  endtask

  // Command-level reference: reply bytes and side effects of one accepted command.
  task automatic model(input logic [47:0] c, input logic [7:0] len, output logic [135:0] rep);
    logic [7:0]   b[6];
    logic [127:0] pl;
    logic [7:0]   rl;
    int           minl;
    bit           known;
    for (int i = 0; i < 6; i++) b[i] = c[8*i +: 8];
    pl = '0;
    rl = 8'd0;
    known = 1'b1;
    minl = 1;
    case (b[0])
      8'h01: minl = 1;
      8'h02: minl = 2;
      8'h03: minl = 6;
      8'h04: minl = 1;
      8'h05: minl = 5;
      default: known = 1'b0;
    endcase
    if (!known) begin
      pl[15:0] = 16'h0180; rl = 8'd2;
    end else if (int'(len) < minl) begin
      pl[15:0] = 16'h0380; rl = 8'd2;
    end else if ((b[0] == 8'h02 && b[1] >= 8'd16) || (b[0] == 8'h03 && b[1] >= 8'd32)) begin
      pl[15:0] = 16'h0280; rl = 8'd2;
    end else begin
      case (b[0])
        8'h01: begin pl[23:0] = 24'hCEBA81; rl = 8'd3; end
        8'h02: begin pl[39:0] = {in_regs[32*b[1] +: 32], 8'h81}; rl = 8'd5; end
        8'h03: begin
          m_out[b[1]] = {b[5], b[4], b[3], b[2]};
          strobe_q.push_back(32'd1 << b[1]);
          pl[7:0] = 8'h81; rl = 8'd1;
        end
        8'h04: begin
          pl[39:0] = {m_stat, 8'h81}; rl = 8'd5;
          m_stat = m_hold & m_en;
        end
        default: begin
          m_en   = {b[4], b[3], b[2], b[1]};
          m_stat = m_stat & m_en;
          pl[7:0] = 8'h81; rl = 8'd1;
        end
      endcase
    end
    rep = {rl, pl};
  endtask

  // Monitor: every reply and every strobe must match the next queued expectation.
  always @(negedge clk) begin
    logic [135:0] e;
    if (tx_packet_wr === 1'b1) begin
      check("wr_while_busy", tx_busy, 0);
      if (rep_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_reply: got len %0d buf %h expected none", tx_payload_len, tx_buf);
      end else begin
        e = rep_q.pop_front();
        check("reply_len", tx_payload_len, e[135:128]);
        check("reply_buf", tx_buf, e[127:0]);
      end
    end
    if (out_strobes !== 32'd0 && !$isunknown(out_strobes)) begin
      if (strobe_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_strobe: got %h expected none", out_strobes);
      end else begin
        check("out_strobes", out_strobes, strobe_q.pop_front());
      end
    end
  end

  task automatic send(input logic [47:0] cmd, input logic [7:0] len, input bit valid,
                      input bit perr, input int busy_cyc, input int drop_int, input int dup_at);
    logic [135:0] e;
    bit           good;
    int           lat;
    good = valid && !perr;
    if (good) begin
      model(cmd, len, e);
      rep_q.push_back(e);
    end
    lat = (busy_cyc + 1 > 2) ? busy_cyc + 1 : 2;
    @(negedge clk);
    rx_buf          = {$urandom(), $urandom(), 16'($urandom()), cmd};
    rx_payload_len  = len;
    rx_buffer_valid = valid;
    rx_packet_error = perr;
    rx_packet_done  = 1'b1;
    tx_busy         = (busy_cyc > 0);
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 1) begin rx_packet_done = 1'b0; rx_buffer_valid = 1'b0; rx_packet_error = 1'b0; end
      if (j == busy_cyc) tx_busy = 1'b0;
      if (j == drop_int) int_in = '0;
      if (dup_at > 0 && j == dup_at) begin
        rx_buf = {80'd0, 48'h01}; rx_payload_len = 8'd1;
        rx_buffer_valid = 1'b1; rx_packet_done = 1'b1;
      end
      if (dup_at > 0 && j == dup_at + 1) begin rx_packet_done = 1'b0; rx_buffer_valid = 1'b0; end
      if (!good) begin
        check("dropped_stays_idle", cmd_busy, 0);
        if (j == 6) break;
      end else if (tx_packet_wr === 1'b1) begin
        check("reply_latency", j, lat);
        break;
      end else if (j == 60) begin
        n_checks++; n_fail++;
        $display("FAIL reply_timeout: got no tx_packet_wr expected one within 60 cycles");
      end else begin
        check("busy_during_cmd", cmd_busy, 1);
      end
    end
    if (good) begin
      @(negedge clk);
      check("idle_after_reply", cmd_busy, 0);
    end
    check_out();
    check("int_pending", int_pending, m_stat != 0);
  endtask

  task automatic pulse_int(input logic [31:0] bits);
    @(negedge clk);
    int_in = bits;
    @(negedge clk);
    int_in = '0;
    m_stat = m_stat | (m_en & bits);
  endtask

  initial begin
    logic [47:0] c;
    logic [7:0]  op, ix, ln;
    bit          vld, per;
    int          bc;

    for (int i = 0; i < 32; i++) m_out[i] = '0;
    m_en = '0; m_stat = '0; m_hold = '0;
    rst = 1'b1; rx_packet_done = 1'b0; rx_packet_error = 1'b0; rx_buffer_valid = 1'b0;
    rx_payload_len = '0; rx_buf = '0; tx_busy = 1'b0; int_in = '0;
    for (int i = 0; i < 16; i++) in_regs[32*i +: 32] = $urandom();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_tx_packet_wr", tx_packet_wr, 0);
    check("reset_tx_payload_len", tx_payload_len, 0);
    check("reset_tx_buf", tx_buf, 0);
    check("reset_out_strobes", out_strobes, 0);
    check("reset_int_pending", int_pending, 0);
    check("reset_cmd_busy", cmd_busy, 0);
    check_out();

    send(48'h01, 8'd1, 1, 0, 0, 0, 0);
    send(48'h12_34_56_78_05_03, 8'd6, 1, 0, 0, 0, 0);
    in_regs[32*3 +: 32] = 32'hA5A5_0F0F;
    send(48'h03_02, 8'd2, 1, 0, 0, 0, 0);
    send(48'h7E, 8'd1, 1, 0, 0, 0, 0);
    send(48'h10_02, 8'd2, 1, 0, 0, 0, 0);
    send(48'h00_00_AA_BB_06_03, 8'd4, 1, 0, 0, 0, 0);
    send(48'h1F_02, 8'd2, 1, 0, 0, 0, 0);
    send(48'hDE_AD_BE_EF_1F_03, 8'd6, 1, 0, 0, 0, 0);
    send(48'h00_00_00_00_20_03, 8'd6, 1, 0, 0, 0, 0);

    send(48'h00_00_00_00_09_05, 8'd5, 1, 0, 0, 0, 0);
    pulse_int(32'h0000_000B);
    check("int_pending_after_pulse", int_pending, 1);
    send(48'h04, 8'd1, 1, 0, 0, 0, 0);
    int_in = 32'h8;
    m_stat = m_stat | (m_en & 32'h8);
    m_hold = 32'h8;
    send(48'h04, 8'd1, 1, 0, 0, 2, 0);
    m_hold = '0;
    send(48'h04, 8'd1, 1, 0, 0, 0, 0);
    pulse_int(32'h0000_0001);
    send(48'h00_00_00_00_00_05, 8'd5, 1, 0, 0, 0, 0);

    send(48'h01, 8'd1, 1, 0, 10, 0, 3);
    send(48'h01, 8'd1, 1, 1, 0, 0, 0);
    send(48'h01, 8'd1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 5) == 0) pulse_int($urandom());
      if ($urandom_range(0, 3) == 0) for (int i = 0; i < 16; i++) in_regs[32*i +: 32] = $urandom();
      op  = ($urandom_range(0, 9) < 8) ? 8'(1 + $urandom_range(0, 4)) : 8'($urandom());
      ix  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 33));
      ln  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'd6;
      c   = {32'($urandom()), ix, op};
      vld = ($urandom_range(0, 11) != 0);
      per = ($urandom_range(0, 11) == 0);
      bc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      send(c, ln, vld, per, (vld && !per) ? bc : 0, 0, 0);
    end

    // Abort a WRITE while it sits in EXEC.
    @(negedge clk);
    rx_buf = {80'd0, 48'h12_34_56_78_07_03};
    rx_payload_len = 8'd6; rx_buffer_valid = 1'b1; rx_packet_done = 1'b1;
    @(negedge clk);
    rx_packet_done = 1'b0; rx_buffer_valid = 1'b0;
    check("busy_before_abort", cmd_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_out[i] = '0;
    m_en = '0; m_stat = '0;
    repeat (5) @(negedge clk);
    check("abort_cmd_busy", cmd_busy, 0);
    check("abort_tx_payload_len", tx_payload_len, 0);
    check("abort_int_pending", int_pending, 0);
    check_out();
    send(48'h01, 8'd1, 1, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    check("reply_queue_drained", rep_q.size(), 0);
    check("strobe_queue_drained", strobe_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
